// File: rtl/arith_pkg.sv
// Shared opcodes, FSM state encoding and iteration-core mode for the
// sequential calculator arithmetic unit.
package arith_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_SLL  = 3'd4;
  localparam logic [2:0] OP_SRL  = 3'd5;
  localparam logic [2:0] OP_SRA  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ITER   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_mode_t;

endpackage

// File: rtl/seq_arithmetic_unit_if.sv
// Start/Done request bus between the operand registers (master) and the
// arithmetic unit (slave).
interface seq_arithmetic_unit_if #(parameter int N = 32);
  logic         Start;
  logic [2:0]   Op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Busy;
  logic         Done;
  logic [N-1:0] Result;
  logic [N-1:0] ResultHi;
  logic         Overflow;
  logic         DivZero;

  modport master (
    output Start, Op, A, B,
    input  Busy, Done, Result, ResultHi, Overflow, DivZero
  );

  modport slave (
    input  Start, Op, A, B,
    output Busy, Done, Result, ResultHi, Overflow, DivZero
  );
endinterface

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned multiply (MSB-first shift-add) and restoring divide,
// one bit per step, sharing a single (2N+1)-bit step adder.
module seq_muldiv_core
  import arith_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         step_i,
  input  md_mode_t     mode_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] hi_o,
  output logic [N-1:0] lo_o
);

  logic [2*N-1:0] acc_q, acc_d;    // product accumulator / partial remainder
  logic [N-1:0]   sr_q, sr_d;      // multiplier / dividend-then-quotient
  logic [N-1:0]   opnd_q, opnd_d;  // multiplicand / divisor
  logic [N:0]     rem_sh;
  logic [2*N:0]   add_x, add_y, add_s;
  logic           add_cin;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    rem_sh  = {acc_q[N-1:0], sr_q[N-1]};
    add_x   = {1'b0, acc_q[2*N-2:0], 1'b0};
    add_y   = {{(N+1){1'b0}}, opnd_q & {N{sr_q[N-1]}}};
    add_cin = 1'b0;
    if (mode_i == MD_DIV) begin
      // Trial subtract as add of the complement; add_s[2N] set means borrow.
      add_x   = {{N{1'b0}}, rem_sh};
      add_y   = ~{{(N+1){1'b0}}, opnd_q};
      add_cin = 1'b1;
    end
    add_s = add_x + add_y + {{(2*N){1'b0}}, add_cin};

    acc_d  = acc_q;
    sr_d   = sr_q;
    opnd_d = opnd_q;
    if (load_i) begin
      acc_d  = '0;
      sr_d   = (mode_i == MD_DIV) ? a_i : b_i;
      opnd_d = (mode_i == MD_DIV) ? b_i : a_i;
    end else if (step_i) begin
      if (mode_i == MD_MUL) begin
        acc_d = add_s[2*N-1:0];
        sr_d  = {sr_q[N-2:0], 1'b0};
      end else if (add_s[2*N]) begin
        acc_d = {{N{1'b0}}, rem_sh[N-1:0]};
        sr_d  = {sr_q[N-2:0], 1'b0};
      end else begin
        acc_d = {{N{1'b0}}, add_s[N-1:0]};
        sr_d  = {sr_q[N-2:0], 1'b1};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      sr_q   <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      sr_q   <= sr_d;
      opnd_q <= opnd_d;
    end
  end

  assign hi_o = (mode_i == MD_DIV) ? acc_q[N-1:0] : acc_q[2*N-1:N];
  assign lo_o = (mode_i == MD_DIV) ? sr_q : acc_q[N-1:0];

endmodule

// File: rtl/seq_arithmetic_unit.sv
// Multi-cycle calculator ALU: IDLE/ITER/FINISH control, single-cycle datapath
// and held result registers around the iterative mul/div core.
module seq_arithmetic_unit
  import arith_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  seq_arithmetic_unit_if.slave  bus
);

  localparam int SW = $clog2(N);

  state_t         state_q, state_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic [2:0]     op_q;
  logic [N-1:0]   a_q, b_q;
  logic [N-1:0]   result_q, result_hi_q;
  logic           ovf_q, dz_q;
  logic [N-1:0]   res_d, hi_d;
  logic           ovf_d, dz_d;
  logic           accept, iter_op;
  logic [N-1:0]   core_hi, core_lo, sum, diff;
  logic [SW-1:0]  amt;
  logic           big;
  md_mode_t       core_mode;

  assign accept  = (state_q == ST_IDLE) && bus.Start;
  assign iter_op = (bus.Op == OP_MUL) || ((bus.Op == OP_DIV) && (bus.B != '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = iter_op ? ST_ITER : ST_FINISH;
        cnt_d   = iter_op ? SW'(N - 1) : '0;
      end
      ST_ITER: if (cnt_q == '0) state_d = ST_FINISH;
               else             cnt_d   = cnt_q - 1'b1;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // While idle the core must see the incoming opcode so the load picks the right operand order.
  assign core_mode = (((state_q == ST_IDLE) ? bus.Op : op_q) == OP_DIV) ? MD_DIV : MD_MUL;

  seq_muldiv_core #(.N(N)) u_core (
    .clk    (Clock),
    .rst_n  (Reset_n),
    .load_i (accept && iter_op),
    .step_i (state_q == ST_ITER),
    .mode_i (core_mode),
    .a_i    (bus.A),
    .b_i    (bus.B),
    .hi_o   (core_hi),
    .lo_o   (core_lo)
  );

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;
  assign amt  = b_q[SW-1:0];
  assign big  = |b_q[N-1:SW];

  always_comb begin
    res_d = '0;
    hi_d  = '0;
    ovf_d = 1'b0;
    dz_d  = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_d = sum;
        ovf_d = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
      end
      OP_SUB: begin
        res_d = diff;
        ovf_d = (a_q[N-1] != b_q[N-1]) && (diff[N-1] != a_q[N-1]);
      end
      OP_MUL: begin
        res_d = core_lo;
        hi_d  = core_hi;
        ovf_d = |core_hi;
      end
      OP_DIV: if (b_q == '0) begin
        res_d = '1;
        hi_d  = a_q;
        dz_d  = 1'b1;
      end else begin
        res_d = core_lo;
        hi_d  = core_hi;
      end
      OP_SLL:  res_d = big ? '0 : (a_q << amt);
      OP_SRL:  res_d = big ? '0 : (a_q >> amt);
      OP_SRA:  res_d = big ? {N{a_q[N-1]}} : $unsigned($signed(a_q) >>> amt);
      OP_PASS: res_d = a_q;
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q <= bus.Op;
        a_q  <= bus.A;
        b_q  <= bus.B;
      end
      if (state_q == ST_FINISH) begin
        result_q    <= res_d;
        result_hi_q <= hi_d;
        ovf_q       <= ovf_d;
        dz_q        <= dz_d;
      end
    end
  end

  // Fresh values are presented during the Done cycle and held from the registers afterwards.
  assign bus.Busy     = (state_q != ST_IDLE);
  assign bus.Done     = (state_q == ST_FINISH);
  assign bus.Result   = bus.Done ? res_d : result_q;
  assign bus.ResultHi = bus.Done ? hi_d  : result_hi_q;
  assign bus.Overflow = bus.Done ? ovf_d : ovf_q;
  assign bus.DivZero  = bus.Done ? dz_d  : dz_q;

endmodule

// File: tb/tb_seq_arithmetic_unit.sv
// Directed vector bench for seq_arithmetic_unit: table of ops with expected
// results/latency plus reset-mid-MUL and Start-while-busy sequences.
module tb_seq_arithmetic_unit;
  import arith_pkg::*;

  localparam int N = 32;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [31:0] exp_hi;
    logic        exp_ovf;
    logic        exp_dz;
    int          exp_lat;
  } vec_t;

  logic Clock;
  logic Reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[16];

  seq_arithmetic_unit_if #(.N(N)) bus ();

  seq_arithmetic_unit #(.N(N)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op and wait (bounded) for Done; outputs are captured in the Done cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [31:0] hi,
                        output logic ovf, output logic dz, output int lat, output int busy_n);
    @(negedge Clock);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge Clock);
    #1;
    bus.Start = 1'b0;
    lat    = 1;
    busy_n = 0;
    while (1) begin
      if (bus.Busy) busy_n++;
      if (bus.Done || lat >= 100) break;
      @(posedge Clock);
      #1;
      lat++;
    end
    res = bus.Result;
    hi  = bus.ResultHi;
    ovf = bus.Overflow;
    dz  = bus.DivZero;
  endtask

  initial begin
    logic [31:0] res, hi;
    logic        ovf, dz;
    int          lat, busy_n;

    vecs[0]  = '{OP_ADD,  32'd5,          32'd7,          32'd12,         32'd0,          1'b0, 1'b0, 1};
    vecs[1]  = '{OP_ADD,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  32'd0,          1'b1, 1'b0, 1};
    vecs[2]  = '{OP_SUB,  32'd3,          32'd5,          32'hFFFF_FFFE,  32'd0,          1'b0, 1'b0, 1};
    vecs[3]  = '{OP_SUB,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b1, 1'b0, 1};
    vecs[4]  = '{OP_MUL,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32'hFFFF_FFFE,  1'b1, 1'b0, 33};
    vecs[5]  = '{OP_MUL,  32'h0001_2345,  32'h0000_0100,  32'h0123_4500,  32'd0,          1'b0, 1'b0, 33};
    vecs[6]  = '{OP_DIV,  32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 33};
    vecs[7]  = '{OP_DIV,  32'd9,          32'd0,          32'hFFFF_FFFF,  32'd9,          1'b0, 1'b1, 1};
    vecs[8]  = '{OP_DIV,  32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 1'b0, 33};
    vecs[9]  = '{OP_SLL,  32'd1,          32'd40,         32'd0,          32'd0,          1'b0, 1'b0, 1};
    vecs[10] = '{OP_SLL,  32'd1,          32'd4,          32'h0000_0010,  32'd0,          1'b0, 1'b0, 1};
    vecs[11] = '{OP_SRL,  32'h8000_0000,  32'd31,         32'd1,          32'd0,          1'b0, 1'b0, 1};
    vecs[12] = '{OP_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000,  32'd0,          1'b0, 1'b0, 1};
    vecs[13] = '{OP_SRA,  32'h8000_0000,  32'd40,         32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 1};
    vecs[14] = '{OP_SRA,  32'h4000_0000,  32'd4,          32'h0400_0000,  32'd0,          1'b0, 1'b0, 1};
    vecs[15] = '{OP_PASS, 32'hDEAD_BEEF,  32'd5,          32'hDEAD_BEEF,  32'd0,          1'b0, 1'b0, 1};

    Reset_n   = 1'b0;
    bus.Start = 1'b0;
    bus.Op    = OP_ADD;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("reset busy",   64'(bus.Busy),     64'd0);
    check("reset done",   64'(bus.Done),     64'd0);
    check("reset result", 64'(bus.Result),   64'd0);
    check("reset hi",     64'(bus.ResultHi), 64'd0);
    check("reset ovf",    64'(bus.Overflow), 64'd0);
    check("reset dz",     64'(bus.DivZero),  64'd0);
    @(negedge Clock);
    Reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, hi, ovf, dz, lat, busy_n);
      check($sformatf("v%0d latency", i), 64'(lat),    64'(vecs[i].exp_lat));
      check($sformatf("v%0d busy",    i), 64'(busy_n), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d result",  i), 64'(res),    64'(vecs[i].exp_res));
      check($sformatf("v%0d hi",      i), 64'(hi),     64'(vecs[i].exp_hi));
      check($sformatf("v%0d ovf",     i), 64'(ovf),    64'(vecs[i].exp_ovf));
      check($sformatf("v%0d dz",      i), 64'(dz),     64'(vecs[i].exp_dz));
      @(posedge Clock);
      #1;
      check($sformatf("v%0d done pulse", i), 64'(bus.Done),   64'd0);
      check($sformatf("v%0d hold",       i), 64'(bus.Result), 64'(vecs[i].exp_res));
    end

    // Reset in the middle of a MUL discards it and clears all outputs.
    @(negedge Clock);
    bus.Start = 1'b1;
    bus.Op    = OP_MUL;
    bus.A     = 32'hFFFF_FFFF;
    bus.B     = 32'd3;
    @(posedge Clock);
    #1;
    bus.Start = 1'b0;
    repeat (9) @(posedge Clock);
    #1;
    check("midmul busy before reset", 64'(bus.Busy), 64'd1);
    Reset_n = 1'b0;
    #1;
    check("midmul busy",   64'(bus.Busy),     64'd0);
    check("midmul done",   64'(bus.Done),     64'd0);
    check("midmul result", 64'(bus.Result),   64'd0);
    check("midmul hi",     64'(bus.ResultHi), 64'd0);
    check("midmul ovf",    64'(bus.Overflow), 64'd0);
    check("midmul dz",     64'(bus.DivZero),  64'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    run_op(OP_ADD, 32'd5, 32'd7, res, hi, ovf, dz, lat, busy_n);
    check("post-reset add latency", 64'(lat), 64'd1);
    check("post-reset add result",  64'(res), 64'd12);
    @(posedge Clock);
    #1;

    // Start held high through a DIV: later requests must not disturb it.
    @(negedge Clock);
    bus.Start = 1'b1;
    bus.Op    = OP_DIV;
    bus.A     = 32'd100;
    bus.B     = 32'd7;
    @(posedge Clock);
    #1;
    bus.Op = OP_ADD;
    bus.A  = 32'd1;
    bus.B  = 32'd1;
    lat = 1;
    while (!bus.Done && lat < 100) begin
      @(posedge Clock);
      #1;
      lat++;
    end
    check("pulsed div latency", 64'(lat),          64'd33);
    check("pulsed div result",  64'(bus.Result),   64'd14);
    check("pulsed div hi",      64'(bus.ResultHi), 64'd2);
    @(posedge Clock);
    #1;
    check("after-done idle busy", 64'(bus.Busy),   64'd0);
    check("after-done hold",      64'(bus.Result), 64'd14);
    @(posedge Clock);
    #1;
    bus.Start = 1'b0;
    check("after-done accept done",   64'(bus.Done),   64'd1);
    check("after-done accept result", 64'(bus.Result), 64'd2);
    @(posedge Clock);
    #1;
    check("after-done accept idle", 64'(bus.Busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
